// File: rtl/alu_pkg.sv
// Shared opcode map and FSM state encoding for the multi-cycle MIPS ALU.
package alu_pkg;

  localparam logic [5:0] OP_SLL  = 6'b000000;
  localparam logic [5:0] OP_SRL  = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_BLEZ = 6'b000110;
  localparam logic [5:0] OP_BGTZ = 6'b000111;
  localparam logic [5:0] OP_MUL  = 6'b011000;
  localparam logic [5:0] OP_DIVU = 6'b011011;
  localparam logic [5:0] OP_ADD  = 6'b100000;
  localparam logic [5:0] OP_SUB  = 6'b100010;
  localparam logic [5:0] OP_AND  = 6'b100100;
  localparam logic [5:0] OP_OR   = 6'b100101;
  localparam logic [5:0] OP_XOR  = 6'b100110;
  localparam logic [5:0] OP_SLT  = 6'b101010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative engine: signed shift-add multiplier (magnitudes + final sign fix)
// and unsigned restoring divider, WIDTH iterations each.
module alu_iter_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic               running;
  logic               fin;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   opnd;
  logic               neg;
  logic               div_mode;
  logic               b_zero;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   diff;
  logic [2*WIDTH-1:0] step;
  logic [2*WIDTH-1:0] fixed;

  // Magnitudes are plain unsigned WIDTH-bit values, so the most negative operand is exact.
  assign mag_a = a[WIDTH-1] ? ({WIDTH{1'b0}} - a) : a;
  assign mag_b = b[WIDTH-1] ? ({WIDTH{1'b0}} - b) : b;

  // One iteration: divide keeps {remainder, quotient} in prod, multiply keeps {partial, multiplier}.
  always_comb begin
    sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    trial = prod[2*WIDTH-1:WIDTH-1];
    diff  = trial[WIDTH-1:0] - opnd;
    if (div_mode) begin
      if (trial >= {1'b0, opnd}) begin
        step = {diff, prod[WIDTH-2:0], 1'b1};
      end else begin
        step = {prod[2*WIDTH-2:0], 1'b0};
      end
    end else begin
      step = {sum, prod[WIDTH-1:1]};
    end
  end

  // Operand load, iteration counter and completion flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      running  <= 1'b0;
      fin      <= 1'b0;
      cnt      <= {CNT_W{1'b0}};
      prod     <= {(2*WIDTH){1'b0}};
      opnd     <= {WIDTH{1'b0}};
      neg      <= 1'b0;
      div_mode <= 1'b0;
      b_zero   <= 1'b0;
    end else if (start) begin
      running  <= 1'b1;
      fin      <= 1'b0;
      cnt      <= {CNT_W{1'b0}};
      div_mode <= is_div;
      b_zero   <= (b == {WIDTH{1'b0}});
      if (is_div) begin
        prod <= {{WIDTH{1'b0}}, a};
        opnd <= b;
        neg  <= 1'b0;
      end else begin
        prod <= {{WIDTH{1'b0}}, mag_b};
        opnd <= mag_a;
        neg  <= a[WIDTH-1] ^ b[WIDTH-1];
      end
    end else if (running) begin
      prod <= step;
      if (cnt == CNT_LAST) begin
        running <= 1'b0;
        fin     <= 1'b1;
        cnt     <= {CNT_W{1'b0}};
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end else begin
      fin <= 1'b0;
    end
  end

  assign fixed    = neg ? ({(2*WIDTH){1'b0}} - prod) : prod;
  assign res_lo   = fixed[WIDTH-1:0];
  assign res_hi   = fixed[2*WIDTH-1:WIDTH];
  assign busy     = running | fin;
  assign done     = fin;
  assign div_zero = div_mode & b_zero;

endmodule

// File: rtl/alu_multicycle.sv
// Handshaked multi-cycle MIPS ALU (EX stage). Define ALU_DIV_EN to add the
// DIVU (unsigned divide) opcode; otherwise that encoding decodes as illegal.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             InValid,
  output logic             InReady,
  input  logic [5:0]       ALUControl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] ALUResult,
  output logic [WIDTH-1:0] ALUHi,
  output logic             Zero,
  output logic             IllegalOp
);

  localparam int SHAMT_W = $clog2(WIDTH);

  state_t           state;
  state_t           next_state;
  logic             accept;
  logic             iter_op;
  logic             iter_div;
  logic             is_branch;
  logic             taken;
  logic             sc_illegal;
  logic             sc_zero;
  logic [WIDTH-1:0] sc_result;
  logic             iter_busy;
  logic             iter_done;
  logic             iter_div_zero;
  logic [WIDTH-1:0] iter_lo;
  logic [WIDTH-1:0] iter_hi;

  assign accept = InValid & InReady;

  // Opcode decode and single-cycle datapath, computed straight from the presented operands.
  always_comb begin
    sc_result  = {WIDTH{1'b0}};
    is_branch  = 1'b0;
    taken      = 1'b0;
    sc_illegal = 1'b0;
    iter_op    = 1'b0;
    iter_div   = 1'b0;
    case (ALUControl)
      OP_ADD:  sc_result = A + B;
      OP_SUB:  sc_result = A - B;
      OP_AND:  sc_result = A & B;
      OP_OR:   sc_result = A | B;
      OP_XOR:  sc_result = A ^ B;
      OP_SLL:  sc_result = A << B[SHAMT_W-1:0];
      OP_SRL:  sc_result = A >> B[SHAMT_W-1:0];
      OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_BEQ:  begin is_branch = 1'b1; taken = (A == B); end
      OP_BNE:  begin is_branch = 1'b1; taken = (A != B); end
      OP_BGTZ: begin is_branch = 1'b1; taken = ~A[WIDTH-1] & (A != {WIDTH{1'b0}}); end
      OP_BLEZ: begin is_branch = 1'b1; taken = A[WIDTH-1] | (A == {WIDTH{1'b0}}); end
      OP_MUL:  iter_op = 1'b1;
`ifdef ALU_DIV_EN
      OP_DIVU: begin iter_op = 1'b1; iter_div = 1'b1; end
`endif
      default: sc_illegal = 1'b1;
    endcase
  end

  assign sc_zero = is_branch ? taken : (sc_result == {WIDTH{1'b0}});

  alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk      (Clk),
    .rst      (Rst),
    .start    (accept & iter_op),
    .is_div   (iter_div),
    .a        (A),
    .b        (B),
    .busy     (iter_busy),
    .done     (iter_done),
    .res_lo   (iter_lo),
    .res_hi   (iter_hi),
    .div_zero (iter_div_zero)
  );

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a DONE result consumed alongside a new op chains with no bubble.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          next_state = iter_op ? ST_BUSY : ST_DONE;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (iter_done) begin
          next_state = ST_DONE;
        end else if (iter_busy) begin
          next_state = ST_BUSY;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (accept) begin
          next_state = iter_op ? ST_BUSY : ST_DONE;
        end else if (OutReady) begin
          next_state = ST_IDLE;
        end else begin
          next_state = ST_DONE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Handshake outputs.
  always_comb begin
    case (state)
      ST_IDLE: begin InReady = 1'b1;     OutValid = 1'b0; end
      ST_BUSY: begin InReady = 1'b0;     OutValid = 1'b0; end
      ST_DONE: begin InReady = OutReady; OutValid = 1'b1; end
      default: begin InReady = 1'b0;     OutValid = 1'b0; end
    endcase
  end

  // Result registers: loaded on single-cycle accept or iteration completion, otherwise held.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      ALUResult <= {WIDTH{1'b0}};
      ALUHi     <= {WIDTH{1'b0}};
      Zero      <= 1'b0;
      IllegalOp <= 1'b0;
    end else if (accept && !iter_op) begin
      ALUResult <= sc_result;
      ALUHi     <= {WIDTH{1'b0}};
      Zero      <= sc_zero;
      IllegalOp <= sc_illegal;
    end else if ((state == ST_BUSY) && iter_done) begin
      ALUResult <= iter_lo;
      ALUHi     <= iter_hi;
      Zero      <= (iter_lo == {WIDTH{1'b0}});
      IllegalOp <= iter_div_zero;
    end
  end

endmodule
